// File: rtl/decode_window_buffer_pkg.sv
// Shared sizing for the decode byte window: window depth, fetch beat width and
// the derived count/data widths used by the buffer and its shifter.
package decode_window_buffer_pkg;
   localparam int WINDOW_BYTES = 12;
   localparam int FETCH_BYTES  = 4;
   localparam int WIN_W        = 8 * WINDOW_BYTES;
   localparam int FETCH_W      = 8 * FETCH_BYTES;
   localparam int CNT_W        = $clog2(WINDOW_BYTES + 1);
   // Highest fill level at which a full fetch beat still fits.
   localparam int ACCEPT_MAX   = WINDOW_BYTES - FETCH_BYTES;
endpackage

// File: rtl/decode_window_shift.sv
// Combinational byte shifter: drops the consumed bytes from the bottom of the
// window and ORs the masked fetch beat in directly above the surviving bytes.
module decode_window_shift
   import decode_window_buffer_pkg::*;
(
   input  logic [WIN_W-1:0]   window,
   input  logic [CNT_W-1:0]   count,
   input  logic [CNT_W-1:0]   consume,
   input  logic [FETCH_W-1:0] fetch_data,
   input  logic [CNT_W-1:0]   fetch_len,
   output logic [WIN_W-1:0]   next_window
);
   logic [FETCH_W-1:0] fetch_masked;
   logic [WIN_W-1:0]   fetch_wide;
   logic [CNT_W-1:0]   index;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      fetch_masked = '0;
      for (int i = 0; i < FETCH_BYTES; i++) begin
         if (CNT_W'(i) < fetch_len) fetch_masked[8*i +: 8] = fetch_data[8*i +: 8];
      end
      fetch_wide  = WIN_W'(fetch_masked);
      // Caller guarantees consume <= count, so the append index never wraps.
      index       = count - consume;
      next_window = (window >> {consume, 3'b000}) | (fetch_wide << {index, 3'b000});
   end
endmodule

// File: rtl/decode_window_buffer.sv
// Byte window between prefetch and instruction decode: holds up to 12 bytes,
// tracks the decode EIP, discards consumed bytes and flushes on restart.
module decode_window_buffer
   import decode_window_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dec_flush,
   input  logic [31:0]          dec_flush_eip,
   input  logic                 fetch_valid,
   input  logic [FETCH_W-1:0]   fetch_bytes,
   input  logic [2:0]           fetch_count,
   output logic                 fetch_accept,
   input  logic                 consume_valid,
   input  logic [3:0]           consume_len,
   output logic [WIN_W-1:0]     decoder,
   output logic [CNT_W-1:0]     decoder_count,
   output logic [31:0]          dec_eip,
   output logic                 consume_err
);
   logic [CNT_W-1:0] c_eff;
   logic [CNT_W-1:0] f_eff;
   logic             over_consume;
   logic [WIN_W-1:0] next_window;

   // Accept depends only on the registered count, never on this cycle's consume.
   assign fetch_accept = (decoder_count <= CNT_W'(ACCEPT_MAX));

   always_comb begin
      over_consume = consume_valid && (consume_len > decoder_count);
      c_eff        = (consume_valid && !over_consume) ? consume_len : '0;
      f_eff        = '0;
      if (fetch_valid && fetch_accept && (fetch_count != 3'd0)
          && (fetch_count <= 3'(FETCH_BYTES)))
         f_eff = CNT_W'(fetch_count);
   end

   decode_window_shift u_shift (
      .window      (decoder),
      .count       (decoder_count),
      .consume     (c_eff),
      .fetch_data  (fetch_bytes),
      .fetch_len   (f_eff),
      .next_window (next_window)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         decoder       <= '0;
         decoder_count <= '0;
         dec_eip       <= '0;
         consume_err   <= 1'b0;
      end else if (dec_flush) begin
         decoder       <= '0;
         decoder_count <= '0;
         dec_eip       <= dec_flush_eip;
      end else begin
         decoder       <= next_window;
         decoder_count <= decoder_count - c_eff + f_eff;
         dec_eip       <= dec_eip + 32'(c_eff);
         if (over_consume) consume_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_decode_window_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a byte-queue reference model of the window.
module tb_decode_window_buffer;
   logic        clk = 1'b0;
   logic        rst, dec_flush, fetch_valid, consume_valid;
   logic [31:0] dec_flush_eip, fetch_bytes;
   logic [2:0]  fetch_count;
   logic [3:0]  consume_len;
   logic        fetch_accept, consume_err;
   logic [95:0] decoder;
   logic [3:0]  decoder_count;
   logic [31:0] dec_eip;

   int checks = 0;
   int failures = 0;

   logic [7:0]  mq[$];
   logic [31:0] m_eip;
   logic        m_err;

   always #5 clk = ~clk;

   decode_window_buffer dut (
      .clk(clk), .rst(rst), .dec_flush(dec_flush), .dec_flush_eip(dec_flush_eip),
      .fetch_valid(fetch_valid), .fetch_bytes(fetch_bytes), .fetch_count(fetch_count),
      .fetch_accept(fetch_accept), .consume_valid(consume_valid), .consume_len(consume_len),
      .decoder(decoder), .decoder_count(decoder_count), .dec_eip(dec_eip),
      .consume_err(consume_err)
   );

   task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [95:0] pack_window();
      logic [95:0] v = '0;
      for (int i = 0; i < mq.size(); i++) v[8*i +: 8] = mq[i];
      return v;
   endfunction

   // Apply one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input logic r, input logic fl, input logic [31:0] feip,
                       input logic fv, input logic [31:0] fb, input logic [2:0] fc,
                       input logic cv, input logic [3:0] cl);
      logic acc;
      rst = r; dec_flush = fl; dec_flush_eip = feip;
      fetch_valid = fv; fetch_bytes = fb; fetch_count = fc;
      consume_valid = cv; consume_len = cl;
      if (r) begin
         mq.delete(); m_eip = 0; m_err = 0;
      end else if (fl) begin
         mq.delete(); m_eip = feip;
      end else begin
         acc = (mq.size() <= 8);
         if (cv) begin
            if (cl > mq.size()) m_err = 1;
            else begin
               for (int i = 0; i < cl; i++) void'(mq.pop_front());
               m_eip = m_eip + 32'(cl);
            end
         end
         if (fv && acc && fc >= 1 && fc <= 4)
            for (int i = 0; i < fc; i++) mq.push_back(fb[8*i +: 8]);
      end
      @(posedge clk);
      #1;
      check("decoder", decoder, pack_window());
      check("count", 96'(decoder_count), 96'(mq.size()));
      check("eip", 96'(dec_eip), 96'(m_eip));
      check("err", 96'(consume_err), 96'(m_err));
      check("accept", 96'(fetch_accept), 96'(mq.size() <= 8));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int sz;
      logic [3:0] cl;
      logic [2:0] fc;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_accept", 96'(fetch_accept), 96'd1);

      // Fill with three full beats.
      step(0, 0, 0, 1, 32'h03020100, 3'd4, 0, 0);
      step(0, 0, 0, 1, 32'h07060504, 3'd4, 0, 0);
      step(0, 0, 0, 1, 32'h0B0A0908, 3'd4, 0, 0);
      check("fill_dec", decoder, 96'h0B0A0908_07060504_03020100);
      check("fill_count", 96'(decoder_count), 96'd12);
      check("fill_accept", 96'(fetch_accept), 96'd0);
      step(0, 0, 0, 1, 32'hDEADBEEF, 3'd4, 0, 0);     // refused while full

      // Consume to 8, then consume 3 with a same-cycle fetch.
      step(0, 0, 0, 0, 0, 0, 1, 4'd4);
      step(0, 0, 0, 1, 32'h13121110, 3'd4, 1, 4'd3);
      check("cf_count", 96'(decoder_count), 96'd9);
      check("cf_byte0", 96'(decoder[7:0]), 96'h07);
      check("cf_eip", 96'(dec_eip), 96'd7);

      // Reach count 10, then flush with a fetch in the same cycle.
      step(0, 0, 0, 0, 0, 0, 1, 4'd3);
      step(0, 0, 0, 1, 32'h23222120, 3'd4, 0, 0);
      check("pre_flush_count", 96'(decoder_count), 96'd10);
      step(0, 1, 32'h0000FFF0, 1, 32'h33323130, 3'd4, 1, 4'd2);
      check("flush_dec", decoder, 96'd0);
      check("flush_eip", 96'(dec_eip), 96'h0000FFF0);

      // Over-consume, then further traffic keeps the error set.
      step(0, 0, 0, 1, 32'h0000BBAA, 3'd2, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 4'd5);
      check("over_count", 96'(decoder_count), 96'd2);
      check("over_err", 96'(consume_err), 96'd1);
      step(0, 0, 0, 1, 32'h44434241, 3'd4, 1, 4'd1);
      step(0, 0, 0, 0, 0, 0, 1, 4'd2);
      check("err_sticky", 96'(consume_err), 96'd1);

      // EIP wrap.
      step(0, 1, 32'hFFFFFFFE, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 32'h57565554, 3'd4, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 4'd4);
      check("eip_wrap", 96'(dec_eip), 96'h2);

      // Partial beat, illegal counts, then reset mid-fill.
      step(0, 0, 0, 1, 32'hAABBCCDD, 3'd1, 0, 0);
      check("partial_dec", decoder, 96'hDD);
      step(0, 0, 0, 1, 32'h11223344, 3'd0, 0, 0);
      step(0, 0, 0, 1, 32'h11223344, 3'd6, 0, 0);
      step(0, 0, 0, 1, 32'h11223344, 3'd3, 0, 0);
      step(1, 0, 0, 1, 32'h55667788, 3'd4, 1, 4'd1);
      check("rst_dec", decoder, 96'd0);
      check("rst_err", 96'(consume_err), 96'd0);
      idle();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         sz = mq.size();
         if ($urandom_range(0, 99) < 15) cl = 4'($urandom_range(0, 15));
         else cl = 4'($urandom_range(1, (sz < 1) ? 1 : sz));
         if ($urandom_range(0, 9) == 0) fc = 3'($urandom_range(0, 7));
         else fc = 3'($urandom_range(1, 4));
         step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0, $urandom,
              $urandom_range(0, 9) < 6, $urandom, fc,
              $urandom_range(0, 1) == 1, cl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
